// File: rtl/instr_prefetch_buf_pkg.sv
// Shared types for the instruction prefetch buffer: bus widths, FIFO entry and issue FSM states.
package instr_prefetch_buf_pkg;

    localparam int InstBus     = 32;
    localparam int InstAddrBus = 32;
    localparam int FETCH_STEP  = 4;

    typedef struct packed {
        logic [InstBus-1:0]     instr;
        logic [InstAddrBus-1:0] pc;
    } fetch_entry_t;

    // ISSUE_WAIT: request raised last cycle without a grant; ISSUE_FLUSH: a redirect happened last cycle.
    typedef enum logic [1:0] {
        ISSUE_IDLE  = 2'd0,
        ISSUE_WAIT  = 2'd1,
        ISSUE_FLUSH = 2'd2
    } issue_state_e;

endpackage

// File: rtl/instr_prefetch_buf_if.sv
// Fetch-side signal bundle: control redirects, instruction bus and the if_id valid/ready output.
// Handshakes: a bus request completes when instr_req_o & instr_gnt_i; an if_id entry transfers when valid_o & ready_i.
interface instr_prefetch_buf_if;
    import instr_prefetch_buf_pkg::*;

    logic                   jump_flag_i;
    logic [InstAddrBus-1:0] jump_addr_i;
    logic                   jtag_reset_flag_i;
    logic                   hold_i;
    logic                   instr_req_o;
    logic [InstAddrBus-1:0] instr_addr_o;
    logic                   instr_gnt_i;
    logic                   instr_rvalid_i;
    logic [InstBus-1:0]     instr_rdata_i;
    logic                   valid_o;
    logic                   ready_i;
    logic [InstBus-1:0]     instr_o;
    logic [InstAddrBus-1:0] pc_o;
    issue_state_e           issue_state;

    modport master (
        input  jump_flag_i, jump_addr_i, jtag_reset_flag_i, hold_i,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, ready_i,
        output instr_req_o, instr_addr_o, valid_o, instr_o, pc_o, issue_state
    );

    modport slave (
        output jump_flag_i, jump_addr_i, jtag_reset_flag_i, hold_i,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, ready_i,
        input  instr_req_o, instr_addr_o, valid_o, instr_o, pc_o, issue_state
    );

endinterface

// File: rtl/instr_prefetch_buf_fifo.sv
// Synchronous FIFO holding fetched instr/pc pairs; supports simultaneous push/pop when full and a clear.
module prefetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  T                           push_data,
    output T                           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T                mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_prefetch_buf.sv
// Pipelined instruction fetcher: credit-limited request issue, in-flight address queue, prefetch FIFO.
// Optional FETCH_BYPASS_EN forwards a response straight to if_id when the FIFO is empty and ready_i is high.
module instr_prefetch_buf
    import instr_prefetch_buf_pkg::*;
#(
    parameter int                     DEPTH     = 4,
    parameter int                     MAX_OUT   = 2,
    parameter logic [InstAddrBus-1:0] BOOT_ADDR = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    instr_prefetch_buf_if.master  fb
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = $clog2(MAX_OUT+1);
    localparam int QW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic                   flush, req, fire, accept, bypass, push, pop;
    logic                   fifo_full, fifo_empty;
    logic [CW-1:0]          fifo_count;
    fetch_entry_t           push_entry, head;
    logic [InstAddrBus-1:0] fetch_pc;
    logic [InstAddrBus-1:0] aq [MAX_OUT];
    logic [QW-1:0]          aq_wr, aq_rd;
    logic [OW-1:0]          out_cnt, out_nxt, discard_cnt, discard_nxt;
    issue_state_e           st_q, st_d;

    // A request is only raised when both the bus credit and the FIFO room for its reply are available.
    assign flush  = fb.jtag_reset_flag_i | fb.jump_flag_i;
    assign req    = !fb.hold_i && !flush && !fifo_full && (out_cnt < OW'(MAX_OUT)) &&
                    ((32'(fifo_count) + 32'(out_cnt)) < 32'(DEPTH));
    assign fire   = req & fb.instr_gnt_i;
    assign accept = fb.instr_rvalid_i && (discard_cnt == '0) && !flush;
`ifdef FETCH_BYPASS_EN
    assign bypass = accept && fifo_empty && fb.ready_i;
`else
    assign bypass = 1'b0;
`endif
    assign push       = accept && !bypass;
    assign pop        = fb.ready_i && !fifo_empty;
    assign push_entry = '{instr: fb.instr_rdata_i, pc: aq[aq_rd]};

    prefetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .clear     (flush),
        .push      (push),
        .pop       (pop),
        .push_data (push_entry),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign fb.instr_req_o  = req;
    assign fb.instr_addr_o = fetch_pc;
    assign fb.valid_o      = !fifo_empty || bypass;
    assign fb.issue_state  = st_q;

    always_comb begin
        fb.instr_o = '0;
        fb.pc_o    = '0;
        if (bypass) begin
            fb.instr_o = fb.instr_rdata_i;
            fb.pc_o    = aq[aq_rd];
        end else if (!fifo_empty) begin
            fb.instr_o = head.instr;
            fb.pc_o    = head.pc;
        end
    end

    // Beats already in flight at a redirect, plus any granted that cycle, must be thrown away.
    assign out_nxt = out_cnt + OW'(fire) - OW'(fb.instr_rvalid_i);

    always_comb begin
        discard_nxt = discard_cnt;
        if (flush)
            discard_nxt = out_nxt;
        else if (fb.instr_rvalid_i && (discard_cnt != '0))
            discard_nxt = discard_cnt - OW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc    <= BOOT_ADDR;
            out_cnt     <= '0;
            discard_cnt <= '0;
            aq_wr       <= '0;
            aq_rd       <= '0;
        end else begin
            out_cnt     <= out_nxt;
            discard_cnt <= discard_nxt;
            if (fb.jtag_reset_flag_i)  fetch_pc <= BOOT_ADDR;
            else if (fb.jump_flag_i)   fetch_pc <= fb.jump_addr_i;
            else if (fire)             fetch_pc <= fetch_pc + InstAddrBus'(FETCH_STEP);
            if (fire)
                aq_wr <= (aq_wr == QW'(MAX_OUT-1)) ? '0 : aq_wr + QW'(1);
            if (fb.instr_rvalid_i)
                aq_rd <= (aq_rd == QW'(MAX_OUT-1)) ? '0 : aq_rd + QW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire) aq[aq_wr] <= fetch_pc;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) st_q <= ISSUE_IDLE;
        else         st_q <= st_d;
    end

    always_comb begin
        st_d = ISSUE_IDLE;
        if (flush)
            st_d = ISSUE_FLUSH;
        else if (req && !fb.instr_gnt_i)
            st_d = ISSUE_WAIT;
    end

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Self-checking bench for instr_prefetch_buf with a latency-programmable bus responder and pc/instr scoreboard.
module tb_instr_prefetch_buf;
  import instr_prefetch_buf_pkg::*;

  localparam logic [31:0] BOOT = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = 2;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_prefetch_buf_if bus_if();

  instr_prefetch_buf #(.DEPTH(4), .MAX_OUT(2), .BOOT_ADDR(BOOT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .fb     (bus_if.master)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int lat = 1;
  int pop_cnt = 0;
  logic [31:0] model_pc = BOOT;
  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // bus responder + scoreboard: grants push expectations, if_id transfers pop and compare
  initial begin
    logic [31:0] e;
    bus_if.instr_rvalid_i = 1'b0;
    bus_if.instr_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus_if.instr_req_o && bus_if.instr_gnt_i) begin
        tests_run++;
        if (bus_if.instr_addr_o !== model_pc) begin
          tests_failed++;
          $display("FAIL issue_addr: got %h expected %h", bus_if.instr_addr_o, model_pc);
        end
        exp_q.push_back(model_pc);
        pend_addr.push_back(bus_if.instr_addr_o);
        pend_due.push_back(cyc + lat);
        model_pc = model_pc + 32'd4;
      end
      if (rst_n && bus_if.valid_o && bus_if.ready_i) begin
        pop_cnt++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_entry: got pc %h expected no entry", bus_if.pc_o);
        end else begin
          e = exp_q.pop_front();
          if (bus_if.pc_o !== e || bus_if.instr_o !== mem_word(e)) begin
            tests_failed++;
            $display("FAIL entry: got pc %h instr %h expected pc %h instr %h",
                     bus_if.pc_o, bus_if.instr_o, e, mem_word(e));
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
      bus_if.instr_rvalid_i = 1'b0;
      bus_if.instr_rdata_i  = '0;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        bus_if.instr_rvalid_i = 1'b1;
        bus_if.instr_rdata_i  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_flush(input logic jtag, input logic jump, input logic [31:0] addr);
    logic saved_ready;
    step();
    saved_ready = bus_if.ready_i;
    bus_if.ready_i = 1'b0;
    bus_if.jtag_reset_flag_i = jtag;
    bus_if.jump_flag_i = jump;
    bus_if.jump_addr_i = addr;
    exp_q.delete();
    model_pc = jtag ? BOOT : addr;
    @(negedge clk);
    tests_run++;
    if (bus_if.instr_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_req: got %b expected 0", bus_if.instr_req_o);
    end
    step();
    bus_if.jtag_reset_flag_i = 1'b0;
    bus_if.jump_flag_i = 1'b0;
    bus_if.ready_i = saved_ready;
    @(negedge clk);
    tests_run++;
    if (bus_if.valid_o !== 1'b0 || bus_if.issue_state !== ISSUE_FLUSH) begin
      tests_failed++;
      $display("FAIL post_flush: got valid %b state %0d expected valid 0 state %0d",
               bus_if.valid_o, bus_if.issue_state, ISSUE_FLUSH);
    end
  endtask

  task automatic drain();
    int t;
    step();
    bus_if.hold_i = 1'b1;
    bus_if.ready_i = 1'b1;
    bus_if.instr_gnt_i = 1'b1;
    t = 0;
    while ((pend_addr.size() != 0 || exp_q.size() != 0 || bus_if.valid_o) && t < 80) begin
      step();
      t++;
    end
    tests_run++;
    if (t >= 80) begin
      tests_failed++;
      $display("FAIL drain: got %0d entries still expected, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    bus_if.jump_flag_i = 1'b0;
    bus_if.jump_addr_i = '0;
    bus_if.jtag_reset_flag_i = 1'b0;
    bus_if.hold_i = 1'b1;
    bus_if.instr_gnt_i = 1'b0;
    bus_if.ready_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus_if.instr_req_o !== 1'b0 || bus_if.valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got req %b valid %b expected 0 0", bus_if.instr_req_o, bus_if.valid_o);
    end
    tests_run++;
    if (bus_if.instr_addr_o !== BOOT || bus_if.instr_o !== 32'h0 || bus_if.pc_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got addr %h instr %h pc %h expected %h 0 0",
               bus_if.instr_addr_o, bus_if.instr_o, bus_if.pc_o, BOOT);
    end
    step();
    rst_n = 1'b1;
    model_pc = BOOT;
    @(negedge clk);
    tests_run++;
    if (bus_if.issue_state !== ISSUE_IDLE || bus_if.valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got state %0d valid %b expected %0d 0",
               bus_if.issue_state, bus_if.valid_o, ISSUE_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    int first_req, first_valid, p0;
    step();
    lat = 1;
    bus_if.instr_gnt_i = 1'b1;
    bus_if.ready_i = 1'b1;
    bus_if.hold_i = 1'b0;
    first_req = -1;
    first_valid = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (first_req < 0 && bus_if.instr_req_o) first_req = k;
      if (first_valid < 0 && bus_if.valid_o) first_valid = k;
    end
    tests_run++;
    if (first_req != 0 || first_valid != FIRST_LAT) begin
      tests_failed++;
      $display("FAIL first_latency: got req@%0d valid@%0d expected req@0 valid@%0d",
               first_req, first_valid, FIRST_LAT);
    end
    step();
    p0 = pop_cnt;
    repeat (6) step();
    tests_run++;
    if (pop_cnt - p0 != 6) begin
      tests_failed++;
      $display("FAIL back_to_back: got %0d entries in 6 cycles expected 6", pop_cnt - p0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    do_flush(1'b1, 1'b0, 32'h0);
    step();
    lat = 1;
    bus_if.ready_i = 1'b0;
    bus_if.hold_i = 1'b0;
    bus_if.instr_gnt_i = 1'b1;
    repeat (10) step();
    @(negedge clk);
    tests_run++;
    if (bus_if.instr_req_o !== 1'b0 || bus_if.valid_o !== 1'b1 || bus_if.pc_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL full_hold: got req %b valid %b pc %h expected 0 1 00000000",
               bus_if.instr_req_o, bus_if.valid_o, bus_if.pc_o);
    end
    step(); #1;
    tests_run++;
    if (exp_q.size() != 4) begin
      tests_failed++;
      $display("FAIL full_count: got %0d fetches issued expected 4", exp_q.size());
    end
    bus_if.ready_i = 1'b1;
    drain();
  endtask

  task automatic test_jump_discard();
    int t;
    logic found;
    step();
    lat = 3;
    bus_if.instr_gnt_i = 1'b1;
    bus_if.ready_i = 1'b1;
    bus_if.hold_i = 1'b0;
    t = 0;
    while (pend_addr.size() < 2 && t < 20) begin
      step();
      t++;
    end
    tests_run++;
    if (t >= 20) begin
      tests_failed++;
      $display("FAIL two_outstanding: got %0d in flight expected 2", pend_addr.size());
    end
    do_flush(1'b0, 1'b1, 32'h100);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus_if.valid_o && bus_if.ready_i) found = 1'b1;
    end
    tests_run++;
    if (!found || bus_if.pc_o !== 32'h100) begin
      tests_failed++;
      $display("FAIL jump_first: got found %b pc %h expected 1 00000100", found, bus_if.pc_o);
    end
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus_if.valid_o && bus_if.ready_i) found = 1'b1;
    end
    tests_run++;
    if (!found || bus_if.pc_o !== 32'h104) begin
      tests_failed++;
      $display("FAIL jump_second: got found %b pc %h expected 1 00000104", found, bus_if.pc_o);
    end
    drain();
    lat = 1;
  endtask

  task automatic test_jtag_priority();
    logic found;
    do_flush(1'b1, 1'b1, 32'h200);
    step();
    lat = 1;
    bus_if.hold_i = 1'b0;
    bus_if.instr_gnt_i = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (bus_if.instr_req_o) found = 1'b1;
    end
    tests_run++;
    if (!found || bus_if.instr_addr_o !== BOOT) begin
      tests_failed++;
      $display("FAIL jtag_priority: got found %b addr %h expected 1 %h", found, bus_if.instr_addr_o, BOOT);
    end
    drain();
  endtask

  task automatic test_gnt_stall();
    logic [31:0] a0;
    step();
    lat = 1;
    bus_if.instr_gnt_i = 1'b0;
    bus_if.hold_i = 1'b0;
    a0 = model_pc;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus_if.instr_req_o !== 1'b1 || bus_if.instr_addr_o !== a0) begin
        tests_failed++;
        $display("FAIL stall_cycle%0d: got req %b addr %h expected 1 %h", k, bus_if.instr_req_o, bus_if.instr_addr_o, a0);
      end
    end
    tests_run++;
    if (bus_if.issue_state !== ISSUE_WAIT) begin
      tests_failed++;
      $display("FAIL stall_state: got %0d expected %0d", bus_if.issue_state, ISSUE_WAIT);
    end
    step();
    bus_if.hold_i = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus_if.instr_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL withdraw: got req %b expected 0", bus_if.instr_req_o);
    end
    step();
    bus_if.hold_i = 1'b0;
    bus_if.instr_gnt_i = 1'b1;
    repeat (6) step();
    drain();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_jump_discard();
    test_jtag_priority();
    test_gnt_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
